// File: rtl/maxnet_pkg.sv
// Shared float field widths, constants, FSM states and the relu helper
// for the MaxNet winner-take-all block.
package maxnet_pkg;

  localparam int FLT_W = 32;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;

  localparam logic [EXP_W-1:0] EXP_MAX       = 8'hFF;
  localparam logic [FLT_W-1:0] FLOAT_ZERO    = 32'h0000_0000;
  localparam logic [FLT_W-1:0] FLOAT_ONE     = 32'h3F80_0000;
  localparam logic [FLT_W-1:0] FLOAT_NEG_ONE = 32'hBF80_0000;

  typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_t;

  // Negative values, -0 and subnormals all collapse to +0.
  function automatic logic [FLT_W-1:0] relu_f(input logic [FLT_W-1:0] x);
    if (x[FLT_W-1] || (x[MAN_W +: EXP_W] == '0)) return FLOAT_ZERO;
    return x;
  endfunction

endpackage

// File: rtl/maxnet_model_fp_addmul.sv
// Combinational fused y = a + b*c in single precision, one truncating rounding,
// subnormals flushed to +0; ovf flags any inf/NaN operand or result exponent >= 255.
module fp_addmul
  import maxnet_pkg::*;
(
  input  logic [FLT_W-1:0] a,
  input  logic [FLT_W-1:0] b,
  input  logic [FLT_W-1:0] c,
  output logic [FLT_W-1:0] y,
  output logic             ovf
);

  localparam int MW = 51;  // exact 48-bit product mantissa plus guard/round/sticky

  logic              a_zero, p_zero, a_big, same_sign, big_sign, found;
  logic signed [9:0] a_exp, p_exp, big_exp, res_exp;
  logic [47:0]       prod, a_man, p_man;
  logic [MW-1:0]     big_man, small_man, small_sh, lost_mask, diff, norm;
  logic [MW:0]       sum;
  logic [9:0]        shamt;
  logic [5:0]        lz;
  logic [MAN_W-1:0]  frac;

  always_comb begin
    y         = FLOAT_ZERO;
    ovf       = 1'b0;
    lost_mask = '0;
    a_zero    = (a[MAN_W +: EXP_W] == '0);
    p_zero    = (b[MAN_W +: EXP_W] == '0) || (c[MAN_W +: EXP_W] == '0);
    prod      = {24'd0, 1'b1, b[MAN_W-1:0]} * {24'd0, 1'b1, c[MAN_W-1:0]};
    p_exp     = $signed({2'b00, b[MAN_W +: EXP_W]}) + $signed({2'b00, c[MAN_W +: EXP_W]})
              - 10'sd127 + (prod[47] ? 10'sd1 : 10'sd0);
    p_man     = prod[47] ? prod : {prod[46:0], 1'b0};
    a_exp     = $signed({2'b00, a[MAN_W +: EXP_W]});
    a_man     = {1'b1, a[MAN_W-1:0], 24'd0};

    if (p_zero)      a_big = 1'b1;
    else if (a_zero) a_big = 1'b0;
    else             a_big = (a_exp > p_exp) || ((a_exp == p_exp) && (a_man >= p_man));

    same_sign = (a[FLT_W-1] == (b[FLT_W-1] ^ c[FLT_W-1]));
    big_sign  = a_big ? a[FLT_W-1] : (b[FLT_W-1] ^ c[FLT_W-1]);
    big_exp   = a_big ? a_exp : p_exp;
    big_man   = {(a_big ? a_man : p_man), 3'b000};
    small_man = ((a_big && p_zero) || (!a_big && a_zero)) ? '0 : {(a_big ? p_man : a_man), 3'b000};
    shamt     = a_big ? $unsigned(a_exp - p_exp) : $unsigned(p_exp - a_exp);

    // Bits shifted out collapse into a sticky bit so truncation stays exact on subtraction.
    if (small_man == '0) begin
      small_sh = '0;
    end else if (shamt >= 10'(MW)) begin
      small_sh = {{(MW-1){1'b0}}, 1'b1};
    end else begin
      lost_mask = ~({MW{1'b1}} << shamt);
      small_sh  = (small_man >> shamt) | {{(MW-1){1'b0}}, |(small_man & lost_mask)};
    end

    sum   = {1'b0, big_man} + {1'b0, small_sh};
    diff  = big_man - small_sh;
    lz    = 6'd0;
    found = 1'b0;
    for (int i = MW - 1; i >= 0; i--) begin
      if (!found) begin
        if (diff[i]) found = 1'b1;
        else         lz = lz + 6'd1;
      end
    end
    norm = diff << lz;

    if (same_sign) begin
      res_exp = big_exp + (sum[MW] ? 10'sd1 : 10'sd0);
      frac    = sum[MW] ? MAN_W'(sum >> (MW - 23)) : MAN_W'(sum >> (MW - 24));
    end else begin
      res_exp = big_exp - $signed({4'b0000, lz});
      frac    = MAN_W'(norm >> (MW - 24));
    end

    if ((a[MAN_W +: EXP_W] == EXP_MAX) || (b[MAN_W +: EXP_W] == EXP_MAX) ||
        (c[MAN_W +: EXP_W] == EXP_MAX))             ovf = 1'b1;
    else if (!p_zero && (p_exp >= 10'sd255))        ovf = 1'b1;
    else if (a_zero && p_zero)                      y   = FLOAT_ZERO;
    else if (!same_sign && (diff == '0))            y   = FLOAT_ZERO;
    else if (res_exp >= 10'sd255)                   ovf = 1'b1;
    else if (res_exp <= 10'sd0)                     y   = FLOAT_ZERO;
    else                                            y   = {big_sign, res_exp[7:0], frac};
  end

endmodule

// File: rtl/maxnet_model.sv
// 4-neuron MaxNet winner-take-all with start/finish handshake.
// Define ITER_LIMIT_EN to abort (finish with overflow) after MAX_ITER iterations.
module maxnet_model
  import maxnet_pkg::*;
#(
  parameter int MAX_ITER = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] eps,
  input  logic [31:0] a1,
  input  logic [31:0] a2,
  input  logic [31:0] a3,
  input  logic [31:0] a4,
  output logic        finish,
  output logic        overflow,
  output logic [31:0] out
);

  state_t      state_reg, state_next;
  logic [31:0] act_reg [4], act_next [4];
  logic [31:0] orig_reg [4], orig_next [4];
  logic [31:0] eps_reg, eps_next, out_reg, out_next, winner;
  logic        finish_reg, finish_next, ovf_reg, ovf_next;
  logic [31:0] ain [4], sum_lvl [3], diff [4], upd [4], upd_relu [4];
  logic [2:0]  sum_ovf;
  logic [3:0]  diff_ovf, upd_ovf, nz;
  logic        any_ovf, converged;

`ifdef ITER_LIMIT_EN
  localparam int CNT_W = $clog2(MAX_ITER + 1);
  logic [CNT_W-1:0] cnt_reg, cnt_next;
`endif

  assign ain[0] = a1;
  assign ain[1] = a2;
  assign ain[2] = a3;
  assign ain[3] = a4;

  // S = (a0 + a1) + (a2 + a3); multiplying by 1.0 is exact so these are plain adds.
  fp_addmul u_s01 (.a(act_reg[0]), .b(act_reg[1]), .c(FLOAT_ONE), .y(sum_lvl[0]), .ovf(sum_ovf[0]));
  fp_addmul u_s23 (.a(act_reg[2]), .b(act_reg[3]), .c(FLOAT_ONE), .y(sum_lvl[1]), .ovf(sum_ovf[1]));
  fp_addmul u_sum (.a(sum_lvl[0]), .b(sum_lvl[1]), .c(FLOAT_ONE), .y(sum_lvl[2]), .ovf(sum_ovf[2]));

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_neuron
      fp_addmul u_diff (.a(sum_lvl[2]), .b(act_reg[gi]), .c(FLOAT_NEG_ONE),
                        .y(diff[gi]), .ovf(diff_ovf[gi]));
      fp_addmul u_upd  (.a(act_reg[gi]), .b(eps_reg), .c(diff[gi]),
                        .y(upd[gi]), .ovf(upd_ovf[gi]));
      assign upd_relu[gi] = relu_f(upd[gi]);
      assign nz[gi]       = (upd_relu[gi] != FLOAT_ZERO);
    end
  endgenerate

  assign any_ovf   = (|sum_ovf) | (|diff_ovf) | (|upd_ovf);
  assign converged = ((nz & (nz - 4'd1)) == 4'd0);

  always_comb begin
    state_next  = state_reg;
    act_next    = act_reg;
    orig_next   = orig_reg;
    eps_next    = eps_reg;
    finish_next = finish_reg;
    ovf_next    = ovf_reg;
    out_next    = out_reg;
`ifdef ITER_LIMIT_EN
    cnt_next    = cnt_reg;
`endif
    winner = FLOAT_ZERO;
    for (int i = 0; i < 4; i++) if (nz[i]) winner = orig_reg[i];

    case (state_reg)
      IDLE: if (start) state_next = LOAD;
      LOAD: begin
        for (int i = 0; i < 4; i++) begin
          orig_next[i] = ain[i];
          act_next[i]  = relu_f(ain[i]);
        end
        eps_next    = eps;
        finish_next = 1'b0;
        ovf_next    = 1'b0;
        out_next    = FLOAT_ZERO;
`ifdef ITER_LIMIT_EN
        cnt_next    = '0;
`endif
        state_next  = ITER;
      end
      ITER: begin
        for (int i = 0; i < 4; i++) act_next[i] = upd_relu[i];
        if (any_ovf) begin
          state_next  = DONE;
          finish_next = 1'b1;
          ovf_next    = 1'b1;
          out_next    = FLOAT_ZERO;
        end else if (converged) begin
          state_next  = DONE;
          finish_next = 1'b1;
          out_next    = winner;
        end
`ifdef ITER_LIMIT_EN
        else if (cnt_reg == CNT_W'(MAX_ITER - 1)) begin
          state_next  = DONE;
          finish_next = 1'b1;
          ovf_next    = 1'b1;
          out_next    = FLOAT_ZERO;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
`endif
      end
      DONE: if (start) state_next = LOAD;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      eps_reg    <= FLOAT_ZERO;
      out_reg    <= FLOAT_ZERO;
      finish_reg <= 1'b0;
      ovf_reg    <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        act_reg[i]  <= FLOAT_ZERO;
        orig_reg[i] <= FLOAT_ZERO;
      end
`ifdef ITER_LIMIT_EN
      cnt_reg    <= '0;
`endif
    end else begin
      state_reg  <= state_next;
      eps_reg    <= eps_next;
      out_reg    <= out_next;
      finish_reg <= finish_next;
      ovf_reg    <= ovf_next;
      act_reg    <= act_next;
      orig_reg   <= orig_next;
`ifdef ITER_LIMIT_EN
      cnt_reg    <= cnt_next;
`endif
    end
  end

  assign finish   = finish_reg;
  assign overflow = ovf_reg;
  assign out      = out_reg;

endmodule

// File: tb/tb_maxnet_model.sv
// Directed bench for maxnet_model: convergence, ties, overflow, async reset.
module tb_maxnet_model;

  localparam logic [31:0] EPS = 32'hBE4CCCCD;

  logic        clk, rst, start, finish, overflow;
  logic [31:0] eps, a1, a2, a3, a4, out;
  int          checks, failures, cyc;

  maxnet_model dut (
    .clk(clk), .rst(rst), .start(start), .eps(eps),
    .a1(a1), .a2(a2), .a3(a3), .a4(a4),
    .finish(finish), .overflow(overflow), .out(out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse start at a negedge, then count rising edges (the first samples start)
  // until finish is seen after the LOAD edge, or the budget runs out.
  task automatic run(input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] v3,
                     input logic [31:0] v4, input int budget, output int ncyc);
    @(negedge clk);
    a1 = v1; a2 = v2; a3 = v3; a4 = v4; eps = EPS;
    start = 1'b1;
    ncyc = budget;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (k + 1 >= 2 && finish) begin
        ncyc = k + 1;
        break;
      end
    end
    $display("run a=%h %h %h %h cycles=%0d finish=%0b overflow=%0b out=%h",
             v1, v2, v3, v4, ncyc, finish, overflow, out);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b0; start = 1'b0; eps = EPS;
    a1 = '0; a2 = '0; a3 = '0; a4 = '0;
    repeat (2) @(posedge clk); #1;
    check("rst_finish", 32'(finish), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_out", out, 32'h0);
    @(negedge clk) rst = 1'b1;

    // 1,2,3,4: five iterations, neuron 4 wins
    run(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 50, cyc);
    check("t1_cycles", 32'(cyc), 32'd7);
    check("t1_finish", 32'(finish), 32'd1);
    check("t1_out", out, 32'h40800000);
    check("t1_overflow", 32'(overflow), 32'd0);
    repeat (3) @(posedge clk); #1;
    check("t1_finish_hold", 32'(finish), 32'd1);

    // -1, 0.5, 0, 0: single survivor after one iteration
    run(32'hBF800000, 32'h3F000000, 32'h00000000, 32'h00000000, 50, cyc);
    check("t4_cycles", 32'(cyc), 32'd3);
    check("t4_out", out, 32'h3F000000);
    check("t4_overflow", 32'(overflow), 32'd0);

    // asynchronous reset while DONE holds nonzero outputs, no clock edge in between
    @(negedge clk); #2;
    rst = 1'b0; #1;
    check("async_finish", 32'(finish), 32'd0);
    check("async_out", out, 32'h0);
    check("async_overflow", 32'(overflow), 32'd0);
    @(negedge clk) rst = 1'b1;

    // 3,1,0,0: two iterations, neuron 1 wins
    run(32'h40400000, 32'h3F800000, 32'h00000000, 32'h00000000, 50, cyc);
    check("idx0_cycles", 32'(cyc), 32'd4);
    check("idx0_out", out, 32'h40400000);
    check("idx0_overflow", 32'(overflow), 32'd0);

    // 2,2,1,1: tied maxima decay together until flushed to zero
    run(32'h40000000, 32'h40000000, 32'h3F800000, 32'h3F800000, 2000, cyc);
    check("tie_finish", 32'(finish), 32'd1);
    check("tie_out", out, 32'h0);
    check("tie_overflow", 32'(overflow), 32'd0);

    // all 2^127: first sum overflows
    run(32'h7F000000, 32'h7F000000, 32'h7F000000, 32'h7F000000, 50, cyc);
    check("ovf_cycles", 32'(cyc), 32'd3);
    check("ovf_finish", 32'(finish), 32'd1);
    check("ovf_overflow", 32'(overflow), 32'd1);
    check("ovf_out", out, 32'h0);

    // all inputs <= 0 (including -0): done after one iteration, no winner
    run(32'hBF800000, 32'h00000000, 32'h80000000, 32'hC0000000, 50, cyc);
    check("neg_cycles", 32'(cyc), 32'd3);
    check("neg_out", out, 32'h0);
    check("neg_overflow", 32'(overflow), 32'd0);

    // reset in the middle of ITER, then the block must idle and rerun cleanly
    @(negedge clk);
    a1 = 32'h3F800000; a2 = 32'h40000000; a3 = 32'h40400000; a4 = 32'h40800000;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk); #1;
    rst = 1'b0; #1;
    check("iter_rst_finish", 32'(finish), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    repeat (8) @(posedge clk); #1;
    check("iter_rst_idle", 32'(finish), 32'd0);
    run(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 50, cyc);
    check("rerun_cycles", 32'(cyc), 32'd7);
    check("rerun_out", out, 32'h40800000);
    check("rerun_overflow", 32'(overflow), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
